periph_write_arbiter: RTL and testbench



---
 rtl/periph_write_arbiter.sv | 68 ++++++
 tb/tb_periph_write_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/periph_write_arbiter.sv
// periph_write_arbiter: shares the register-bank write port between an edge-strobed host and the core store path.
module periph_write_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              core_valid,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  output logic              core_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic              host_pending,
  output logic              host_drop,
  output logic [7:0]        drop_count
);
  logic              we_q, last_grant;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              host_edge, grant_host, grant_core, load, drop;
  // On conflict the requester that did not win last time gets the port.
  always_comb begin
    host_edge  = host_we & ~we_q;
    grant_host = ena & host_pending & (~core_valid | last_grant);
    grant_core = ena & core_valid & (~host_pending | ~last_grant);
    load       = ena & host_edge & (~host_pending | grant_host);
    drop       = ena & host_edge & host_pending & ~grant_host;
  end
  assign core_ready = ena & grant_core;
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      last_grant   <= 1'b1;
      buf_addr     <= '0;
      buf_data     <= '0;
      host_pending <= 1'b0;
      host_drop    <= 1'b0;
      drop_count   <= 8'd0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_src       <= 1'b0;
    end else begin
      we_q         <= host_we;
      host_pending <= load | (host_pending & ~grant_host);
      host_drop    <= drop;
      wr_en        <= grant_host | grant_core;
      if (load) begin
        buf_addr <= host_addr;
        buf_data <= host_data;
      end
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (grant_host | grant_core) begin
        last_grant <= grant_core;
        wr_src     <= grant_core;
        wr_addr    <= grant_core ? core_addr : buf_addr;
        wr_data    <= grant_core ? core_data : buf_data;
      end
    end
  end
endmodule

// File: tb/tb_periph_write_arbiter.sv
// tb_periph_write_arbiter: directed stimulus checked every cycle against a queue-based model plus literal spot checks.
module tb_periph_write_arbiter;
  logic       clk, rst, ena, host_we, core_valid;
  logic [1:0] host_addr, core_addr, wr_addr;
  logic [7:0] host_data, core_data, wr_data, drop_count;
  logic       core_ready, wr_en, wr_src, host_pending, host_drop;
  int n_cmp = 0, n_err = 0;

  periph_write_arbiter dut (
    .clk(clk), .rst(rst), .ena(ena), .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .core_valid(core_valid), .core_addr(core_addr),
    .core_data(core_data), .core_ready(core_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_src(wr_src), .host_pending(host_pending),
    .host_drop(host_drop), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] a; logic [7:0] d;} hent_t;
  hent_t      hq[$];
  bit         m_prev, m_lg, chk = 0;
  logic       e_wr_en, e_src, e_drop;
  logic [1:0] e_addr;
  logic [7:0] e_data, e_cnt;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit core_wins();
    return hq.size() == 0 ? 1'b1 : (core_valid ? !m_lg : 1'b0);
  endfunction

  always @(posedge clk) begin : model
    bit cw, rise;
    hent_t h;
    if (rst) begin
      hq.delete();
      m_prev = 0; m_lg = 1; chk = 1;
      e_wr_en = 0; e_src = 0; e_addr = 0; e_data = 0; e_drop = 0; e_cnt = 0;
    end else begin
      rise = host_we && !m_prev;
      cw = core_wins();
      e_wr_en = ena && (hq.size() != 0 || core_valid);
      e_drop = 0;
      if (e_wr_en) begin
        m_lg = cw;
        e_src = cw;
        if (cw) begin
          e_addr = core_addr; e_data = core_data;
        end else begin
          h = hq.pop_front(); e_addr = h.a; e_data = h.d;
        end
      end
      if (rise && ena) begin
        if (hq.size() == 0) hq.push_back(hent_t'({host_addr, host_data}));
        else begin
          e_drop = 1;
          if (e_cnt != 8'hFF) e_cnt++;
        end
      end
      m_prev = host_we;
    end
  end

  always @(negedge clk) if (chk) begin
    cmp("core_ready", 32'(core_ready), 32'(ena && core_valid && core_wins()));
    cmp("wr_en", 32'(wr_en), 32'(e_wr_en));
    cmp("wr_addr", 32'(wr_addr), 32'(e_addr));
    cmp("wr_data", 32'(wr_data), 32'(e_data));
    cmp("wr_src", 32'(wr_src), 32'(e_src));
    cmp("host_pending", 32'(host_pending), 32'(hq.size() != 0));
    cmp("host_drop", 32'(host_drop), 32'(e_drop));
    cmp("drop_count", 32'(drop_count), 32'(e_cnt));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; ena = 0; host_we = 0; host_addr = 0; host_data = 0;
    core_valid = 0; core_addr = 0; core_data = 0;
    step(2);
    cmp("rst_wr_en", 32'(wr_en), 0);
    cmp("rst_pending", 32'(host_pending), 0);
    cmp("rst_drop_count", 32'(drop_count), 0);
    rst = 0; ena = 1;
    step(1);
    // single host strobe: write lands two cycles after the edge
    host_addr = 2; host_data = 8'h5A; host_we = 1;
    step(1);
    host_we = 0;
    cmp("t1_pending", 32'(host_pending), 1);
    cmp("t1_early", 32'(wr_en), 0);
    step(1);
    cmp("t1_wr_en", 32'(wr_en), 1);
    cmp("t1_addr", 32'(wr_addr), 2);
    cmp("t1_data", 32'(wr_data), 32'h5A);
    cmp("t1_src", 32'(wr_src), 0);
    step(1);
    cmp("t1_once", 32'(wr_en), 0);
    // core burst
    for (int i = 0; i < 4; i++) begin
      core_valid = 1; core_addr = 2'(i); core_data = 8'(8'h10 + i);
      #1 cmp("t2_ready", 32'(core_ready), 1);
      step(1);
      cmp("t2_data", 32'(wr_data), 32'(8'h10 + i));
      cmp("t2_src", 32'(wr_src), 1);
    end
    core_valid = 0;
    step(2);
    // contention with host strobes every other cycle
    core_valid = 1; core_addr = 3; host_addr = 1;
    for (int k = 0; k < 8; k++) begin
      host_we = (k % 2 == 0); host_data = 8'(8'hB0 + k); core_data = 8'(8'hC0 + k);
      step(1);
    end
    core_valid = 0; host_we = 0;
    step(3);
    cmp("t3_no_drop", 32'(drop_count), 0);
    // ena gating
    ena = 0; host_we = 1; host_data = 8'hAA; core_valid = 1;
    #1 cmp("t5_ready_off", 32'(core_ready), 0);
    step(1);
    host_we = 0;
    step(1);
    cmp("t5_no_write", 32'(wr_en), 0);
    cmp("t5_no_drop", 32'(drop_count), 0);
    ena = 1; core_valid = 0; host_data = 8'h55; host_we = 1;
    step(1);
    host_we = 0;
    step(1);
    cmp("t5_host_wr", 32'(wr_en), 1);
    cmp("t5_host_data", 32'(wr_data), 32'h55);
    core_valid = 1; core_addr = 1; core_data = 8'hD1;
    #1 cmp("t5_ready_on", 32'(core_ready), 1);
    step(1);
    cmp("t5_core_data", 32'(wr_data), 32'hD1);
    cmp("t5_core_src", 32'(wr_src), 1);
    core_valid = 0;
    // host write so the host is the last winner
    host_data = 8'h33; host_we = 1;
    step(1);
    host_we = 0;
    step(2);
    // overflow: buffer frozen a cycle, then the core wins while a second edge arrives
    host_data = 8'h01; host_we = 1;
    step(1);
    ena = 0; host_we = 0;
    step(1);
    ena = 1; core_valid = 1; core_data = 8'hC5; host_data = 8'h02; host_we = 1;
    step(1);
    cmp("t4_drop", 32'(host_drop), 1);
    cmp("t4_count", 32'(drop_count), 1);
    cmp("t4_core_first", 32'(wr_data), 32'hC5);
    host_we = 0; core_valid = 0;
    step(1);
    cmp("t4_host_data", 32'(wr_data), 32'h01);
    cmp("t4_drop_pulse", 32'(host_drop), 0);
    step(2);
    // saturate the drop counter
    for (int i = 0; i < 620; i++) begin
      ena = 1; core_valid = 1; host_we = 1; host_data = 8'(i);
      step(1);
      ena = 0; host_we = 0;
      step(1);
    end
    cmp("sat_count", 32'(drop_count), 255);
    ena = 1; core_valid = 0;
    step(3);
    // reset mid-operation
    host_addr = 1; host_data = 8'h77; host_we = 1;
    step(1);
    cmp("t6_pending", 32'(host_pending), 1);
    core_valid = 1; rst = 1;
    step(1);
    cmp("t6_wr_en", 32'(wr_en), 0);
    cmp("t6_pending_clr", 32'(host_pending), 0);
    cmp("t6_count_clr", 32'(drop_count), 0);
    cmp("t6_data_clr", 32'(wr_data), 0);
    rst = 0; core_valid = 0; host_we = 0;
    step(4);
    cmp("t6_no_stale", 32'(wr_en), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
